// File: rtl/scan_link_arbiter.sv
// Round-robin owner of the shared upload link between the two scanners:
// grants one scanner, streams a bounded burst onto the link, flushes the owner and releases.
module scan_link_arbiter #(
    parameter int BURST_MAX = 10,
    parameter int TIMEOUT   = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_transfer,
    input  logic [1:0] req,
    input  logic [3:0] buf_count_0,
    input  logic [3:0] buf_count_1,
    input  logic       link_ready,
    output logic [1:0] grant,
    output logic       link_valid,
    output logic [1:0] rd_en,
    output logic [1:0] flush,
    output logic [3:0] xfer_count,
    output logic       done,
    output logic       abort,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Clamp a scanner's buffered word count to the per-grant burst limit.
    function automatic logic [3:0] sat_burst(input logic [3:0] cnt);
        if (cnt > 4'(BURST_MAX)) return 4'(BURST_MAX);
        return cnt;
    endfunction

    state_t      state_q, state_d;
    logic        pending_q, pending_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic        abort_flag_q, abort_flag_d;
    logic [3:0]  xfer_q, xfer_d;
    logic [7:0]  stall_q, stall_d;
    logic [3:0]  remaining_q, remaining_d;

    logic        winner;
    logic [3:0]  burst_len;
    logic [7:0]  stall_inc;
    logic [1:0]  owner_oh;

    // With both scanners requesting, the one that did not own the link last time wins.
    assign winner    = (req == 2'b11) ? ~last_owner_q : req[1];
    assign burst_len = sat_burst(winner ? buf_count_1 : buf_count_0);
    assign stall_inc = stall_q + 8'd1;
    assign owner_oh  = owner_q ? 2'b10 : 2'b01;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            pending_q    <= 1'b0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            abort_flag_q <= 1'b0;
            xfer_q       <= 4'd0;
            stall_q      <= 8'd0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            abort_flag_q <= abort_flag_d;
            xfer_q       <= xfer_d;
            stall_q      <= stall_d;
        end
    end

    // Burst word counter is pure datapath; it is always reloaded on a grant.
    always_ff @(posedge clk) begin
        remaining_q <= remaining_d;
    end

    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q | start_transfer;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        abort_flag_d = abort_flag_q;
        xfer_d       = xfer_q;
        stall_d      = stall_q;
        remaining_d  = remaining_q;

        case (state_q)
            IDLE: begin
                if (pending_q && (req != 2'b00)) begin
                    // A new pulse on the granting edge arms the following transfer.
                    pending_d   = start_transfer;
                    owner_d     = winner;
                    remaining_d = burst_len;
                    xfer_d      = 4'd0;
                    stall_d     = 8'd0;
                    state_d     = (burst_len == 4'd0) ? FLUSH : XFER;
                end
            end
            XFER: begin
                if (link_ready) begin
                    remaining_d = remaining_q - 4'd1;
                    xfer_d      = xfer_q + 4'd1;
                    stall_d     = 8'd0;
                    if (remaining_q == 4'd1) state_d = FLUSH;
                end else begin
                    stall_d = stall_inc;
                    if (stall_inc == 8'(TIMEOUT)) begin
                        state_d      = FLUSH;
                        abort_flag_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                state_d = DONE;
            end
            DONE: begin
                last_owner_d = owner_q;
                abort_flag_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Everything except rd_en is decoded from registered state and owner only.
    assign grant      = ((state_q == XFER) || (state_q == FLUSH)) ? owner_oh : 2'b00;
    assign link_valid = (state_q == XFER);
    assign rd_en      = ((state_q == XFER) && link_ready) ? owner_oh : 2'b00;
    assign flush      = (state_q == FLUSH) ? owner_oh : 2'b00;
    assign abort      = (state_q == FLUSH) && abort_flag_q;
    assign done       = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign xfer_count = xfer_q;

endmodule

// File: tb/tb_scan_link_arbiter.sv
// Directed bench for scan_link_arbiter: per-cycle output logs checked against hand-derived timelines.
module tb_scan_link_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_transfer;
    logic [1:0] req;
    logic [3:0] buf_count_0;
    logic [3:0] buf_count_1;
    logic       link_ready;
    logic [1:0] grant;
    logic       link_valid;
    logic [1:0] rd_en;
    logic [1:0] flush;
    logic [3:0] xfer_count;
    logic       done;
    logic       abort;
    logic       busy;

    int errs   = 0;
    int checks = 0;

    logic [1:0] g_log [64];
    logic [1:0] rd_log[64];
    logic [1:0] fl_log[64];
    logic       lv_log[64];
    logic       dn_log[64];
    logic       ab_log[64];
    logic       by_log[64];
    logic [3:0] xc_log[64];
    int         run_len;

    scan_link_arbiter #(.BURST_MAX(10), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .start_transfer(start_transfer), .req(req),
        .buf_count_0(buf_count_0), .buf_count_1(buf_count_1), .link_ready(link_ready),
        .grant(grant), .link_valid(link_valid), .rd_en(rd_en), .flush(flush),
        .xfer_count(xfer_count), .done(done), .abort(abort), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered at posedge+1 of cycle 0; inputs driven there, outputs logged mid-cycle.
    task automatic run(input logic [63:0] start_m, input logic [63:0] ready_m, input int n);
        run_len = n;
        for (int c = 0; c < n; c++) begin
            start_transfer = start_m[c];
            link_ready     = ready_m[c];
            #4;
            g_log[c]  = grant;
            rd_log[c] = rd_en;
            fl_log[c] = flush;
            lv_log[c] = link_valid;
            dn_log[c] = done;
            ab_log[c] = abort;
            by_log[c] = busy;
            xc_log[c] = xfer_count;
            tick();
        end
        start_transfer = 1'b0;
    endtask

    function automatic int count_rd(input int bit_i);
        int k = 0;
        for (int c = 0; c < run_len; c++) if (rd_log[c][bit_i]) k++;
        return k;
    endfunction

    function automatic int count_grant(input logic [1:0] val);
        int k = 0;
        for (int c = 0; c < run_len; c++) if (g_log[c] == val) k++;
        return k;
    endfunction

    initial begin
        reset          = 1'b0;
        start_transfer = 1'b0;
        req            = 2'b00;
        buf_count_0    = 4'd0;
        buf_count_1    = 4'd0;
        link_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_xfer_count", xfer_count, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        tick();

        // Single burst of 4 words from scanner 0
        req = 2'b01; buf_count_0 = 4'd4;
        run(64'h1, '1, 10);
        chk("b_grant_c1", g_log[1], 0);
        chk("b_busy_c1", by_log[1], 0);
        chk("b_grant_c2", g_log[2], 1);
        chk("b_lv_c2", lv_log[2], 1);
        chk("b_grant_c5", g_log[5], 1);
        chk("b_grant_c6", g_log[6], 1);
        chk("b_grant_c7", g_log[7], 0);
        chk("b_rd0_pulses", count_rd(0), 4);
        chk("b_rd1_pulses", count_rd(1), 0);
        chk("b_flush_c5", fl_log[5], 0);
        chk("b_flush_c6", fl_log[6], 1);
        chk("b_lv_c6", lv_log[6], 0);
        chk("b_abort_c6", ab_log[6], 0);
        chk("b_done_c6", dn_log[6], 0);
        chk("b_done_c7", dn_log[7], 1);
        chk("b_xfer_count_c7", xc_log[7], 4);
        chk("b_xfer_count_hold", xc_log[9], 4);

        // Reset with 3 words outstanding
        req = 2'b01; buf_count_0 = 4'd5;
        run(64'h1, '1, 4);
        link_ready = 1'b1;
        #1;
        chk("r_grant_before", grant, 1);
        reset = 1'b0;
        #1;
        chk("r_grant", grant, 0);
        chk("r_link_valid", link_valid, 0);
        chk("r_rd_en", rd_en, 0);
        chk("r_flush", flush, 0);
        chk("r_busy", busy, 0);
        chk("r_xfer_count", xfer_count, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        run(64'h0, '1, 8);
        chk("r_no_regrant", count_grant(2'b00), 8);

        // Both requesting: alternate owners, never both granted
        req = 2'b11; buf_count_0 = 4'd3; buf_count_1 = 4'd3;
        run(64'h3, '1, 16);
        chk("rr_first_c2", g_log[2], 1);
        chk("rr_second_c8", g_log[8], 2);
        chk("rr_never_both", count_grant(2'b11), 0);
        chk("rr_rd0", count_rd(0), 3);
        chk("rr_rd1", count_rd(1), 3);
        chk("rr_flush_c5", fl_log[5], 1);
        chk("rr_flush_c11", fl_log[11], 2);
        chk("rr_done_c12", dn_log[12], 1);

        // Burst clamped to BURST_MAX
        req = 2'b10; buf_count_0 = 4'd0; buf_count_1 = 4'd13;
        run(64'h1, '1, 16);
        chk("bm_rd1", count_rd(1), 10);
        chk("bm_grant_c11", g_log[11], 2);
        chk("bm_lv_c12", lv_log[12], 0);
        chk("bm_flush_c12", fl_log[12], 2);
        chk("bm_done_c13", dn_log[13], 1);
        chk("bm_xfer_count", xc_log[13], 10);

        // Timeout after 2 accepted words
        req = 2'b01; buf_count_0 = 4'd5; buf_count_1 = 4'd0;
        run(64'h1, 64'hC, 24);
        chk("to_rd0", count_rd(0), 2);
        chk("to_lv_c18", lv_log[18], 1);
        chk("to_flush_c18", fl_log[18], 0);
        chk("to_abort_c18", ab_log[18], 0);
        chk("to_flush_c19", fl_log[19], 1);
        chk("to_abort_c19", ab_log[19], 1);
        chk("to_done_c20", dn_log[20], 1);
        chk("to_abort_c20", ab_log[20], 0);
        chk("to_xfer_count", xc_log[20], 2);

        // Empty grant to scanner 1
        req = 2'b10; buf_count_0 = 4'd0; buf_count_1 = 4'd0;
        run(64'h1, '1, 6);
        chk("e_grant_c2", g_log[2], 2);
        chk("e_lv_c2", lv_log[2], 0);
        chk("e_flush_c2", fl_log[2], 2);
        chk("e_done_c3", dn_log[3], 1);
        chk("e_grant_c3", g_log[3], 0);
        chk("e_rd_total", count_rd(0) + count_rd(1), 0);
        chk("e_xfer_count", xc_log[4], 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
